// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM state constants and burst control struct for
// the memory-backed burst responder.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Burst shape latched at the address handshake.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } burst_ctl_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 bus bundle between an interconnect master port and the memory slave.
interface axi4_burst_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     S_AWID;
  logic [ADDR_WIDTH-1:0]   S_AWADDR;
  logic [7:0]              S_AWLEN;
  logic [2:0]              S_AWSIZE;
  logic [1:0]              S_AWBURST;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_WIDTH-1:0]   S_WDATA;
  logic [DATA_WIDTH/8-1:0] S_WSTRB;
  logic                    S_WLAST;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [ID_WIDTH-1:0]     S_BID;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;
  logic [ID_WIDTH-1:0]     S_ARID;
  logic [ADDR_WIDTH-1:0]   S_ARADDR;
  logic [7:0]              S_ARLEN;
  logic [2:0]              S_ARSIZE;
  logic [1:0]              S_ARBURST;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [ID_WIDTH-1:0]     S_RID;
  logic [DATA_WIDTH-1:0]   S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RLAST;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport slave (
    input  S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    output S_AWREADY,
    input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    output S_WREADY,
    output S_BID, S_BRESP, S_BVALID,
    input  S_BREADY,
    input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID,
    output S_ARREADY,
    output S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    input  S_RREADY
  );

  modport master (
    output S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    input  S_AWREADY,
    output S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    input  S_WREADY,
    input  S_BID, S_BRESP, S_BVALID,
    output S_BREADY,
    output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID,
    input  S_ARREADY,
    input  S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    output S_RREADY
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts plus burst-shape error flag.
// Illegal shapes (reserved BURST, bad WRAP length) step like INCR.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  burst_ctl_t            ctl,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  burst_err
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

  logic [ADDR_WIDTH-1:0] step, wrap_mask, incr;
  logic                  wrap_ok;

  // Wrap window is (LEN+1)*step bytes, aligned to its own size.
  always_comb begin
    step      = ADDR_WIDTH'(1) << ctl.size;
    wrap_mask = ((ADDR_WIDTH'(ctl.len) + ADDR_WIDTH'(1)) << ctl.size) - ADDR_WIDTH'(1);
    incr      = addr + step;
    wrap_ok   = wrap_len_ok(ctl.len);
    case (ctl.burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
      default:     next_addr = incr;
    endcase
    burst_err = (ctl.burst == 2'b11) ||
                ((ctl.burst == BURST_WRAP) && !wrap_ok) ||
                (ctl.size > MAX_SIZE);
  end
endmodule

// File: rtl/axi4_burst_mem_slave.sv
// Synthesizable AXI4 burst memory slave: independent read/write FSMs over a
// word array, registered reads, per-beat range checking.
module axi4_burst_mem_slave
  import axi4_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_SIZE   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi4_burst_mem_slave_if.slave s,
  output logic                  mem_ready
);
  localparam int                    IDX_W     = $clog2(MEM_SIZE);
  localparam int                    NB        = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[ADDR_WIDTH] && (off[ADDR_WIDTH-1:0] < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  // ---------------- write channel ----------------
  logic [1:0]            w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, aw_cur, aw_next;
  burst_ctl_t            w_ctl, aw_ctl_cur;
  logic [7:0]            w_cnt;
  logic                  w_err, aw_berr, aw_fire, w_fire, w_last_beat;

  // Before the handshake the generator sees the incoming request so the
  // burst error is known when it is latched.
  assign aw_cur     = (w_state == W_IDLE) ? s.S_AWADDR : w_addr;
  assign aw_ctl_cur = (w_state == W_IDLE) ? {s.S_AWLEN, s.S_AWSIZE, s.S_AWBURST} : w_ctl;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_aw_gen (
    .addr(aw_cur), .ctl(aw_ctl_cur), .next_addr(aw_next), .burst_err(aw_berr)
  );

  assign s.S_AWREADY = mem_ready && (w_state == W_IDLE);
  assign s.S_WREADY  = (w_state == W_DATA);
  assign s.S_BVALID  = (w_state == W_RESP);
  assign s.S_BID     = w_id;
  assign s.S_BRESP   = w_err ? RESP_SLVERR : RESP_OKAY;

  assign aw_fire     = s.S_AWVALID && s.S_AWREADY;
  assign w_fire      = s.S_WVALID && s.S_WREADY;
  assign w_last_beat = (w_cnt == w_ctl.len);

  // Write FSM: beat count alone ends the burst; WLAST only feeds the error flag.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_ctl   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_fire) begin
          w_id    <= s.S_AWID;
          w_addr  <= s.S_AWADDR;
          w_ctl   <= aw_ctl_cur;
          w_cnt   <= '0;
          w_err   <= aw_berr;
          w_state <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          w_addr <= aw_next;
          w_cnt  <= w_cnt + 8'd1;
          if (!in_range(w_addr) || (s.S_WLAST != w_last_beat)) w_err <= 1'b1;
          if (w_last_beat) w_state <= W_RESP;
        end
        W_RESP: if (s.S_BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (w_fire && in_range(w_addr)) begin
      for (int b = 0; b < NB; b++)
        if (s.S_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= s.S_WDATA[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  logic [0:0]            r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, ar_cur, ar_next;
  burst_ctl_t            r_ctl, ar_ctl_cur;
  logic [7:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp, rd_resp;
  logic                  r_last, ar_berr, ar_fire, r_fire, ar_ok;
  logic [IDX_W-1:0]      ar_idx;

  // r_addr always holds the address of the next beat to be fetched.
  assign ar_cur     = (r_state == R_IDLE) ? s.S_ARADDR : r_addr;
  assign ar_ctl_cur = (r_state == R_IDLE) ? {s.S_ARLEN, s.S_ARSIZE, s.S_ARBURST} : r_ctl;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ar_gen (
    .addr(ar_cur), .ctl(ar_ctl_cur), .next_addr(ar_next), .burst_err(ar_berr)
  );

  assign ar_ok   = in_range(ar_cur);
  assign ar_idx  = word_idx(ar_cur);
  assign rd_resp = (ar_berr || !ar_ok) ? RESP_SLVERR : RESP_OKAY;

  assign s.S_ARREADY = mem_ready && (r_state == R_IDLE);
  assign s.S_RVALID  = (r_state == R_DATA);
  assign s.S_RID     = r_id;
  assign s.S_RDATA   = r_data;
  assign s.S_RRESP   = r_resp;
  assign s.S_RLAST   = r_last;

  assign ar_fire = s.S_ARVALID && s.S_ARREADY;
  assign r_fire  = s.S_RVALID && s.S_RREADY;

  // Read FSM: fetch a beat on AR handshake and on every non-last R handshake,
  // so the beat registers hold still while the master stalls.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_ctl   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_resp  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_fire) begin
          r_id    <= s.S_ARID;
          r_ctl   <= ar_ctl_cur;
          r_addr  <= ar_next;
          r_cnt   <= '0;
          r_data  <= ar_ok ? mem[ar_idx] : '0;
          r_resp  <= rd_resp;
          r_last  <= (s.S_ARLEN == 8'd0);
          r_state <= R_DATA;
        end
        R_DATA: if (r_fire) begin
          if (r_last) begin
            r_state <= R_IDLE;
          end else begin
            r_addr <= ar_next;
            r_cnt  <= r_cnt + 8'd1;
            r_data <= ar_ok ? mem[ar_idx] : '0;
            r_resp <= rd_resp;
            r_last <= ((r_cnt + 8'd1) == r_ctl.len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Status: low in reset, high from the first clock edge after release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) mem_ready <= 1'b0;
    else        mem_ready <= 1'b1;
  end
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Scoreboard bench for axi4_burst_mem_slave: stimulus tasks push expected
// B/R responses, a negedge monitor pops and compares on each handshake.
module tb_axi4_burst_mem_slave;
  import axi4_pkg::*;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  logic clk, rst, mem_ready;
  int   n_chk = 0;
  int   n_pass = 0;

  rexp_t      exp_r[$];
  logic [5:0] exp_b[$];
  logic [31:0] dv[16];
  logic [31:0] ev[16];

  axi4_burst_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi4_burst_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_SIZE(1024), .BASE_ADDR(32'h0)
  ) dut (
    .ACLK(clk), .ARESET(rst), .s(bus.slave), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Hold the valid until ready is seen at a clock edge; returns at posedge+1.
  task automatic hs(input int ch);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      case (ch)
        0:       ok = bus.S_AWREADY;
        1:       ok = bus.S_WREADY;
        default: ok = bus.S_ARREADY;
      endcase
      @(posedge clk);
      n++;
    end
    #1;
    if (!ok) timeout("handshake");
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [3:0] strb, input int early,
                    input logic [1:0] resp);
    int n;
    exp_b.push_back({id, resp});
    bus.S_AWID = id; bus.S_AWADDR = addr; bus.S_AWLEN = len;
    bus.S_AWSIZE = 3'd2; bus.S_AWBURST = burst; bus.S_AWVALID = 1'b1;
    hs(0);
    bus.S_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.S_WDATA  = dv[i];
      bus.S_WSTRB  = strb;
      bus.S_WLAST  = (early >= 0) ? (i == early) : (i == int'(len));
      bus.S_WVALID = 1'b1;
      hs(1);
    end
    bus.S_WVALID = 1'b0;
    bus.S_WLAST  = 1'b0;
    chk("bvalid_after_last_beat", 64'(bus.S_BVALID), 64'(1));
    n = 0;
    while (exp_b.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (exp_b.size() != 0) begin
      timeout("b_response");
      exp_b.delete();
    end
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [1:0] resp, input bit toggle);
    int n;
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back('{id: id, data: ev[i], resp: resp, last: (i == int'(len))});
    bus.S_ARID = id; bus.S_ARADDR = addr; bus.S_ARLEN = len;
    bus.S_ARSIZE = 3'd2; bus.S_ARBURST = burst; bus.S_ARVALID = 1'b1;
    hs(2);
    bus.S_ARVALID = 1'b0;
    chk("rvalid_cycle_after_ar", 64'(bus.S_RVALID), 64'(1));
    n = 0;
    while (exp_r.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      if (toggle) bus.S_RREADY = !bus.S_RREADY;
      n++;
    end
    if (exp_r.size() != 0) begin
      timeout("r_beats");
      exp_r.delete();
    end
    bus.S_RREADY = 1'b1;
  endtask

  // Monitor: compare every handshaked beat/response against the queues and
  // require the read beat to hold while stalled.
  logic [38:0] cur_r, prev_r;
  bit          stalled;
  rexp_t       e_r;
  logic [5:0]  e_b;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      cur_r = {bus.S_RID, bus.S_RRESP, bus.S_RLAST, bus.S_RDATA};
      if (stalled && bus.S_RVALID) chk("r_hold_while_stalled", 64'(cur_r), 64'(prev_r));
      stalled = bus.S_RVALID && !bus.S_RREADY;
      prev_r  = cur_r;
      if (bus.S_RVALID && bus.S_RREADY) begin
        if (exp_r.size() == 0) begin
          n_chk++;
          $display("FAIL r_unexpected: got beat %0h with no beat expected", cur_r);
        end else begin
          e_r = exp_r.pop_front();
          chk("r_beat", 64'(cur_r), 64'({e_r.id, e_r.resp, e_r.last, e_r.data}));
        end
      end
      if (bus.S_BVALID && bus.S_BREADY) begin
        if (exp_b.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected: got %0h with no response expected", {bus.S_BID, bus.S_BRESP});
        end else begin
          e_b = exp_b.pop_front();
          chk("b_resp", 64'({bus.S_BID, bus.S_BRESP}), 64'(e_b));
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.S_AWID = '0; bus.S_AWADDR = '0; bus.S_AWLEN = '0; bus.S_AWSIZE = '0;
    bus.S_AWBURST = '0; bus.S_AWVALID = 1'b0;
    bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WLAST = 1'b0; bus.S_WVALID = 1'b0;
    bus.S_BREADY = 1'b1;
    bus.S_ARID = '0; bus.S_ARADDR = '0; bus.S_ARLEN = '0; bus.S_ARSIZE = '0;
    bus.S_ARBURST = '0; bus.S_ARVALID = 1'b0;
    bus.S_RREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst_awready", 64'(bus.S_AWREADY), 64'(0));
    chk("rst_arready", 64'(bus.S_ARREADY), 64'(0));
    chk("rst_wready",  64'(bus.S_WREADY),  64'(0));
    chk("rst_bvalid",  64'(bus.S_BVALID),  64'(0));
    chk("rst_rvalid",  64'(bus.S_RVALID),  64'(0));
    chk("rst_rdata",   64'(bus.S_RDATA),   64'(0));
    chk("rst_mem_ready", 64'(mem_ready),   64'(0));
    rst = 1'b0;
    #1;
    chk("mem_ready_before_edge", 64'(mem_ready), 64'(0));
    @(posedge clk); #1;
    chk("mem_ready_after_edge", 64'(mem_ready), 64'(1));
    chk("arready_after_reset", 64'(bus.S_ARREADY), 64'(1));
    chk("awready_after_reset", 64'(bus.S_AWREADY), 64'(1));

    // INCR write/read LEN=3 at 0x10
    for (int i = 0; i < 4; i++) dv[i] = 32'hA0 + 32'(i);
    wr(4'd5, 32'h10, 8'd3, BURST_INCR, 4'hF, -1, RESP_OKAY);
    for (int i = 0; i < 4; i++) ev[i] = 32'hA0 + 32'(i);
    rd(4'd6, 32'h10, 8'd3, BURST_INCR, RESP_OKAY, 0);

    // WRAP read LEN=3 at 0x18 over words 1..4
    for (int i = 0; i < 4; i++) dv[i] = 32'(i + 1);
    wr(4'd1, 32'h10, 8'd3, BURST_INCR, 4'hF, -1, RESP_OKAY);
    ev[0] = 32'd3; ev[1] = 32'd4; ev[2] = 32'd1; ev[3] = 32'd2;
    rd(4'd2, 32'h18, 8'd3, BURST_WRAP, RESP_OKAY, 0);

    // FIXED read repeats one word; illegal WRAP length reads as INCR with SLVERR
    ev[0] = 32'd2; ev[1] = 32'd2; ev[2] = 32'd2;
    rd(4'd14, 32'h14, 8'd2, BURST_FIXED, RESP_OKAY, 0);
    ev[0] = 32'd1; ev[1] = 32'd2; ev[2] = 32'd3;
    rd(4'd15, 32'h10, 8'd2, BURST_WRAP, RESP_SLVERR, 0);

    // byte strobe merge
    dv[0] = 32'h1122_3344;
    wr(4'd3, 32'h40, 8'd0, BURST_INCR, 4'hF, -1, RESP_OKAY);
    dv[0] = 32'hAABB_CCDD;
    wr(4'd3, 32'h40, 8'd0, BURST_INCR, 4'b0010, -1, RESP_OKAY);
    ev[0] = 32'h1122_CC44;
    rd(4'd4, 32'h40, 8'd0, BURST_INCR, RESP_OKAY, 0);

    // LEN=7 read with RREADY toggling every cycle
    for (int i = 0; i < 8; i++) dv[i] = 32'h100 + 32'(i);
    wr(4'd7, 32'h80, 8'd7, BURST_INCR, 4'hF, -1, RESP_OKAY);
    for (int i = 0; i < 8; i++) ev[i] = 32'h100 + 32'(i);
    rd(4'd8, 32'h80, 8'd7, BURST_INCR, RESP_OKAY, 1);

    // error writes: out of range, and early WLAST (no strobes)
    dv[0] = 32'h55;
    wr(4'd0, 32'h0, 8'd0, BURST_INCR, 4'hF, -1, RESP_OKAY);
    dv[0] = 32'hBAD0_BAD0;
    wr(4'd9, 32'h1000, 8'd0, BURST_INCR, 4'hF, -1, RESP_SLVERR);
    for (int i = 0; i < 4; i++) dv[i] = 32'hDEAD_0000 + 32'(i);
    wr(4'd10, 32'h10, 8'd3, BURST_INCR, 4'h0, 1, RESP_SLVERR);
    ev[0] = 32'h55;
    rd(4'd11, 32'h0, 8'd0, BURST_INCR, RESP_OKAY, 0);
    for (int i = 0; i < 4; i++) ev[i] = 32'(i + 1);
    rd(4'd12, 32'h10, 8'd3, BURST_INCR, RESP_OKAY, 0);
    ev[0] = 32'h0;
    rd(4'd13, 32'h1000, 8'd0, BURST_INCR, RESP_SLVERR, 0);

    // reset during beat 2 of an 8-beat read
    for (int i = 0; i < 8; i++)
      exp_r.push_back('{id: 4'd1, data: 32'h100 + 32'(i), resp: RESP_OKAY, last: (i == 7)});
    bus.S_ARID = 4'd1; bus.S_ARADDR = 32'h80; bus.S_ARLEN = 8'd7;
    bus.S_ARSIZE = 3'd2; bus.S_ARBURST = BURST_INCR; bus.S_ARVALID = 1'b1;
    hs(2);
    bus.S_ARVALID = 1'b0;
    n = 0;
    while (exp_r.size() > 6 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (exp_r.size() > 6) timeout("reset_burst_progress");
    rst = 1'b1;
    #1;
    chk("rvalid_drops_in_reset", 64'(bus.S_RVALID), 64'(0));
    chk("rlast_zero_in_reset", 64'(bus.S_RLAST), 64'(0));
    chk("mem_ready_low_in_reset", 64'(mem_ready), 64'(0));
    exp_r.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arready_after_rerelease", 64'(bus.S_ARREADY), 64'(1));
    chk("mem_ready_after_rerelease", 64'(mem_ready), 64'(1));
    for (int i = 0; i < 8; i++) ev[i] = 32'h100 + 32'(i);
    rd(4'd2, 32'h80, 8'd7, BURST_INCR, RESP_OKAY, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
